dec_scan_seq: RTL and testbench

Registered, parametrised N-to-2^N one-hot decoder with an optional auto-scan sequencer. In decode mode it latches a select value and drives a one-hot output. In scan mode it steps the active output up or down at a programmable rate, wrapping at the ends. It generalises the combinational 4-to-16 decoder into a clocked output-select / scanner for LED, display-digit and channel-enable use.

---
 rtl/dec_scan_seq.sv | 85 ++++++++
 tb/tb_dec_scan_seq.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dec_scan_seq.sv
// dec_scan_seq: registered N-to-2^N one-hot decoder with an auto-scan sequencer.
// In decode mode the index holds the last loaded select value. In scan mode the
// index steps up or down once every DIV enabled clocks and wraps at the ends.
// The one-hot output is registered from the next index, so y never lags idx.

module dec_scan_seq #(
    parameter int N   = 4,
    parameter int DIV = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           load,
    input  logic [N-1:0]   w,
    input  logic           scan,
    input  logic           dir,
    output logic [2**N-1:0] y,
    output logic [N-1:0]   idx,
    output logic           wrap
);

    localparam int              PCW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PCW-1:0]  PC_LAST = PCW'(DIV - 1);
    localparam logic [N-1:0]    IDX_MAX = '1;

    logic [PCW-1:0]  pc;
    logic [PCW-1:0]  pc_nxt;
    logic [N-1:0]    idx_nxt;
    logic            wrap_nxt;
    logic [2**N-1:0] y_nxt;

    // Next index, prescaler count and wrap flag, in load > enable > mode > prescale priority.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
        idx_nxt  = idx;
        pc_nxt   = pc;
        wrap_nxt = 1'b0;
        if (load) begin
            idx_nxt = w;
            pc_nxt  = '0;
        end else if (!en) begin
            // Disabled: index and prescaler both freeze.
            pc_nxt = pc;
        end else if (!scan) begin
            // Decode mode keeps the prescaler parked so a later scan starts a full period.
            pc_nxt = '0;
        end else if (pc != PC_LAST) begin
            pc_nxt = pc + PCW'(1);
        end else begin
            pc_nxt = '0;
            if (dir) begin
                idx_nxt  = idx - N'(1);
                wrap_nxt = (idx == '0);
            end else begin
                idx_nxt  = idx + N'(1);
                wrap_nxt = (idx == IDX_MAX);
            end
        end
    end

    // One-hot of the index being registered this edge; all zeros when disabled.
    always_comb begin
        y_nxt = '0;
        if (en) begin
            y_nxt[idx_nxt] = 1'b1;
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            pc   <= '0;
            y    <= '0;
            wrap <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples pre-edge values, independent of statement order.
            idx  <= idx_nxt;
            pc   <= pc_nxt;
            y    <= y_nxt;
            wrap <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_dec_scan_seq.sv
// Bench for dec_scan_seq: two instances (DIV=1 and DIV=3) share all inputs.
// A behavioural model counts enabled scan clocks and steps a modulo-16 index;
// directed scenarios use expected values written out by hand.

module tb_dec_scan_seq;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [3:0]  w;
    logic        scan;
    logic        dir;
    logic [15:0] y1, y3;
    logic [3:0]  idx1, idx3;
    logic        wrap1, wrap3;

    int errors = 0;
    int checks = 0;

    // Model state, element 0 tracks the DIV=1 instance, element 1 the DIV=3 one.
    int          m_idx [2];
    int          m_cnt [2];
    bit          m_wrap[2];
    logic [15:0] m_y   [2];

    logic [15:0] yo   [2];
    logic [3:0]  io   [2];
    logic        wo   [2];

    assign yo[0] = y1;
    assign yo[1] = y3;
    assign io[0] = idx1;
    assign io[1] = idx3;
    assign wo[0] = wrap1;
    assign wo[1] = wrap3;

    dec_scan_seq #(.N(4), .DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .w(w),
        .scan(scan), .dir(dir), .y(y1), .idx(idx1), .wrap(wrap1)
    );

    dec_scan_seq #(.N(4), .DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load), .w(w),
        .scan(scan), .dir(dir), .y(y3), .idx(idx3), .wrap(wrap3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_idx[k]  = 0;
            m_cnt[k]  = 0;
            m_wrap[k] = 1'b0;
            m_y[k]    = 16'h0;
        end
    endtask

    // Apply one clock edge of the behavioural rules to the model.
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (load) begin
                m_idx[k] = int'(w);
                m_cnt[k] = 0;
            end else if (!en) begin
                m_cnt[k] = m_cnt[k];
            end else if (!scan) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k] = m_cnt[k] + 1;
                if (m_cnt[k] == div_of(k)) begin
                    m_cnt[k] = 0;
                    if (dir) begin
                        m_wrap[k] = (m_idx[k] == 0);
                        m_idx[k]  = (m_idx[k] + 15) % 16;
                    end else begin
                        m_wrap[k] = (m_idx[k] == 15);
                        m_idx[k]  = (m_idx[k] + 1) % 16;
                    end
                end
            end
            m_y[k] = en ? (16'h1 << m_idx[k]) : 16'h0;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; w = '0; scan = 1'b0; dir = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (io[k] !== 4'd0 || yo[k] !== 16'h0 || wo[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset inst=%0d got idx=%0d y=%h wrap=%b exp idx=0 y=0000 wrap=0",
                         k, io[k], yo[k], wo[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (io[k] !== 4'd0 || yo[k] !== 16'h0) begin
                errors++;
                $display("FAIL reset_release inst=%0d got idx=%0d y=%h exp idx=0 y=0000", k, io[k], yo[k]);
            end
        end
    endtask

    task automatic test_decode();
        logic [3:0]  wv [8] = '{4'd0, 4'd2, 4'd4, 4'd7, 4'd14, 4'd13, 4'd12, 4'd10};
        logic [15:0] ev [8] = '{16'h0001, 16'h0004, 16'h0010, 16'h0080,
                                16'h4000, 16'h2000, 16'h1000, 16'h0400};
        en = 1'b1; scan = 1'b0; dir = 1'b0;
        for (int i = 0; i < 8; i++) begin
            load = 1'b1; w = wv[i];
            tick();
            load = 1'b0;
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (io[k] !== wv[i] || yo[k] !== ev[i]) begin
                    errors++;
                    $display("FAIL decode inst=%0d w=%0d got idx=%0d y=%h exp idx=%0d y=%h",
                             k, wv[i], io[k], yo[k], wv[i], ev[i]);
                end
            end
        end
        // Decode mode holds the index across further clocks.
        tick();
        checks++;
        if (idx1 !== 4'd10 || y1 !== 16'h0400) begin
            errors++;
            $display("FAIL decode_hold got idx=%0d y=%h exp idx=10 y=0400", idx1, y1);
        end
    endtask

    task automatic test_enable();
        en = 1'b1; scan = 1'b0; load = 1'b1; w = 4'd5;
        tick();
        load = 1'b0;
        checks++;
        if (y1 !== 16'h0020 || idx1 !== 4'd5) begin
            errors++;
            $display("FAIL enable_load got idx=%0d y=%h exp idx=5 y=0020", idx1, y1);
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (yo[k] !== 16'h0 || io[k] !== 4'd5) begin
                    errors++;
                    $display("FAIL enable_off inst=%0d cyc=%0d got idx=%0d y=%h exp idx=5 y=0000",
                             k, i, io[k], yo[k]);
                end
            end
        end
        en = 1'b1;
        tick();
        checks++;
        if (y1 !== 16'h0020 || idx1 !== 4'd5) begin
            errors++;
            $display("FAIL enable_on got idx=%0d y=%h exp idx=5 y=0020", idx1, y1);
        end
    endtask

    task automatic test_scan_up();
        int ei [9] = '{14, 14, 15, 15, 15, 0, 0, 0, 1};
        bit ew [9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        logic [15:0] ey;
        en = 1'b1; scan = 1'b1; dir = 1'b0; load = 1'b1; w = 4'd14;
        tick();
        load = 1'b0;
        checks++;
        if (idx3 !== 4'd14 || y3 !== 16'h4000 || wrap3 !== 1'b0) begin
            errors++;
            $display("FAIL scan_up_load got idx=%0d y=%h wrap=%b exp idx=14 y=4000 wrap=0", idx3, y3, wrap3);
        end
        for (int i = 0; i < 9; i++) begin
            tick();
            ey = 16'h1 << ei[i];
            checks++;
            if (idx3 !== 4'(ei[i]) || y3 !== ey || wrap3 !== ew[i]) begin
                errors++;
                $display("FAIL scan_up step=%0d got idx=%0d y=%h wrap=%b exp idx=%0d y=%h wrap=%b",
                         i, idx3, y3, wrap3, ei[i], ey, ew[i]);
            end
        end
    endtask

    task automatic test_scan_down();
        int ei [3] = '{0, 15, 14};
        bit ew [3] = '{0, 1, 0};
        logic [15:0] ey;
        en = 1'b1; scan = 1'b1; dir = 1'b1; load = 1'b1; w = 4'd1;
        tick();
        load = 1'b0;
        checks++;
        if (idx1 !== 4'd1 || y1 !== 16'h0002) begin
            errors++;
            $display("FAIL scan_down_load got idx=%0d y=%h exp idx=1 y=0002", idx1, y1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            ey = 16'h1 << ei[i];
            checks++;
            if (idx1 !== 4'(ei[i]) || y1 !== ey || wrap1 !== ew[i]) begin
                errors++;
                $display("FAIL scan_down step=%0d got idx=%0d y=%h wrap=%b exp idx=%0d y=%h wrap=%b",
                         i, idx1, y1, wrap1, ei[i], ey, ew[i]);
            end
        end
        dir = 1'b0;
        tick();
        checks++;
        if (idx1 !== 4'd15 || y1 !== 16'h8000 || wrap1 !== 1'b0) begin
            errors++;
            $display("FAIL scan_dir_flip got idx=%0d y=%h wrap=%b exp idx=15 y=8000 wrap=0", idx1, y1, wrap1);
        end
    endtask

    task automatic test_priority();
        en = 1'b1; scan = 1'b1; dir = 1'b0; load = 1'b1; w = 4'd15;
        tick();
        w = 4'd3;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (io[k] !== 4'd3 || wo[k] !== 1'b0 || yo[k] !== 16'h0008) begin
                errors++;
                $display("FAIL prio_load inst=%0d got idx=%0d y=%h wrap=%b exp idx=3 y=0008 wrap=0",
                         k, io[k], yo[k], wo[k]);
            end
        end
        w = 4'd15;
        tick();
        en = 1'b0; w = 4'd3;
        tick();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (io[k] !== 4'd3 || yo[k] !== 16'h0 || wo[k] !== 1'b0) begin
                errors++;
                $display("FAIL prio_load_en0 inst=%0d got idx=%0d y=%h wrap=%b exp idx=3 y=0000 wrap=0",
                         k, io[k], yo[k], wo[k]);
            end
        end
        load = 1'b0; en = 1'b1;
    endtask

    task automatic test_async_reset();
        en = 1'b1; scan = 1'b1; dir = 1'b0; load = 1'b1; w = 4'd8;
        tick();
        load = 1'b0;
        tick();
        checks++;
        if (idx1 !== 4'd9 || y1 !== 16'h0200) begin
            errors++;
            $display("FAIL areset_pre got idx=%0d y=%h exp idx=9 y=0200", idx1, y1);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (io[k] !== 4'd0 || yo[k] !== 16'h0 || wo[k] !== 1'b0) begin
                errors++;
                $display("FAIL areset_mid inst=%0d got idx=%0d y=%h wrap=%b exp idx=0 y=0000 wrap=0",
                         k, io[k], yo[k], wo[k]);
            end
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (idx1 !== 4'd1 || y1 !== 16'h0002) begin
            errors++;
            $display("FAIL areset_resume got idx=%0d y=%h exp idx=1 y=0002", idx1, y1);
        end
        checks++;
        if (idx3 !== 4'd0 || y3 !== 16'h0001) begin
            errors++;
            $display("FAIL areset_resume_div3 got idx=%0d y=%h exp idx=0 y=0001", idx3, y3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 15) == 0);
            en   = ($urandom_range(0, 7) != 0);
            scan = ($urandom_range(0, 3) != 0);
            dir  = ($urandom_range(0, 9) < 3);
            w    = 4'($urandom_range(0, 15));
            tick();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (io[k] !== 4'(m_idx[k]) || yo[k] !== m_y[k] || wo[k] !== m_wrap[k]) begin
                    errors++;
                    $display("FAIL random inst=%0d cyc=%0d got idx=%0d y=%h wrap=%b exp idx=%0d y=%h wrap=%b",
                             k, i, io[k], yo[k], wo[k], m_idx[k], m_y[k], m_wrap[k]);
                end
                checks++;
                if ($countones(yo[k]) > 1) begin
                    errors++;
                    $display("FAIL onehot inst=%0d cyc=%0d got y=%h exp at most one bit set", k, i, yo[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_enable();
        test_scan_up();
        test_scan_down();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
